mp64_mbox_initiator: RTL and testbench
======================================

MP64_MBOX_INITIATOR -- requirements
Module: mp64_mbox_initiator

Interface
REQ-001 Parameter NUM_CORES, default 4, number of cores; legal target IDs are 0..NUM_CORES-1.
REQ-002 Parameter RETRY_MAX, default 16, maximum spinlock acquire attempts per command.
REQ-003 Parameter BACKOFF, default 4, idle cycles between acquire attempts.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at a clock edge.
REQ-008 cmd_op  in  2  0=SEND, 1=ACK, 2=LOCK, 3=UNLOCK.
REQ-009 cmd_arg  in  3  target core (SEND), source core (ACK), or lock index 0..7 (LOCK/UNLOCK).
REQ-010 cmd_data  in  64  message payload for SEND; ignored otherwise.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_status  out  2  0=OK, 1=LOCK_BUSY, 2=BAD_ARG; valid with rsp_valid.
REQ-013 req  out  1  MMIO request to mailbox/spinlock responder.
REQ-014 addr  out  12  MMIO offset.
REQ-015 wdata  out  8  MMIO write byte.
REQ-016 wen  out  1  1=write, 0=read.
REQ-017 rdata  in  8  MMIO read byte, sampled on the edge where ack is high.
REQ-018 ack  in  1  MMIO completion; may be combinational in the same cycle as req.

Function
REQ-019 State machine states: IDLE, DATA, SEND, ACK, LOCK_RD, WAIT, UNLOCK, DONE.
REQ-020 Each MMIO transaction holds req, addr, wdata, wen stable until an edge with ack=1; exactly one transaction completes per such edge; req deasserts in IDLE, WAIT, DONE.
REQ-021 SEND: DATA issues 8 writes to 0x500..0x507, byte k = cmd_data[8k+7:8k], k ascending; then SEND writes {5'd0,cmd_arg} to 0x509; then DONE; minimum 9 transaction cycles plus 1 DONE cycle with ack tied high.
REQ-022 ACK: one write of {5'd0,cmd_arg} to 0x50A, then DONE.
REQ-023 LOCK: read 0x600+4*cmd_arg; rdata[0]=0 -> DONE status OK; rdata[0]=1 -> retry per REQ-033/034.
REQ-024 UNLOCK: one write of 0x00 to 0x601+4*cmd_arg, then DONE status OK.
REQ-025 SEND or ACK with cmd_arg >= NUM_CORES: no bus traffic, DONE next cycle with status BAD_ARG.
REQ-026 DONE lasts one cycle, asserts rsp_valid, returns to IDLE; cmd_ready rises the following cycle.
REQ-027 cmd_data, cmd_op, cmd_arg are captured at acceptance; later input changes have no effect.
REQ-028 Attempt counter is 5 bits, cleared at LOCK acceptance, incremented per completed acquire read.
REQ-029 No command is accepted while busy; cmd_valid held high is serviced on return to IDLE.

Reset
REQ-030 rst high forces IDLE immediately regardless of in-flight transaction; req, wen, rsp_valid = 0; addr, wdata = 0; rsp_status = 0; counters cleared; cmd_ready = 0 while rst is high.
REQ-031 Interrupted commands produce no rsp_valid; after rst deasserts, cmd_ready = 1 on the first edge.
REQ-032 A lock acquired before reset is not released by this block.

Configuration
REQ-033 Macro MP64_MBOX_LOCK_RETRY_EN defined: busy read -> WAIT for BACKOFF cycles -> LOCK_RD again; after RETRY_MAX busy reads -> DONE status LOCK_BUSY.
REQ-034 Macro undefined: single acquire read; busy -> DONE status LOCK_BUSY; RETRY_MAX and BACKOFF unused.

Verification
REQ-035 SEND arg=2 data=0x1122334455667788, ack=1 -> writes 0x500..0x507 = 88,77,66,55,44,33,22,11, then 0x509=0x02, rsp_valid with status 0 on the 10th cycle after acceptance.
REQ-036 SEND arg=5, NUM_CORES=4 -> req never asserts, rsp_valid next cycle with status 2.
REQ-037 LOCK arg=3, responder returns 1,1,0 with RETRY_EN defined, BACKOFF=4 -> three reads of 0x60C separated by 4 idle cycles, status 0.
REQ-038 LOCK arg=1, responder always 1, RETRY_EN defined, RETRY_MAX=16 -> exactly 16 reads of 0x604, status 1; RETRY_EN undefined -> exactly 1 read, status 1.
REQ-039 ACK arg=0 with ack held low 3 cycles -> req/addr=0x50A/wdata=0x00 stable all 4 cycles, one transaction, status 0.
REQ-040 Assert rst during DATA byte 4 of a SEND -> req=0 immediately, no rsp_valid; next UNLOCK arg=7 -> write 0x61D, status 0.

Source files
------------

// File: rtl/mp64_mbox_initiator.sv
// mp64_mbox_initiator: turns mailbox/spinlock commands into byte-wide MMIO transactions.
// Define MP64_MBOX_LOCK_RETRY_EN to retry busy lock acquires with a BACKOFF gap, up to RETRY_MAX reads.
module mp64_mbox_initiator #(
  parameter int NUM_CORES = 4,
  parameter int RETRY_MAX = 16,
  parameter int BACKOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_arg,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic        req,
  output logic [11:0] addr,
  output logic [7:0]  wdata,
  output logic        wen,
  input  logic [7:0]  rdata,
  input  logic        ack
);
`ifdef MP64_MBOX_LOCK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DATA, SEND, ACK, LOCK_RD, WAIT, UNLOCK, DONE} state_t;
  state_t state, state_nx;
  logic [63:0] data_r;
  logic [2:0] arg_r, idx;
  logic [4:0] attempts, att_nx;
  logic [15:0] wait_cnt;
  logic [1:0] status_r, status_nx;
  logic accept, bad_arg, give_up, unused_rdata;
  assign accept = cmd_valid && cmd_ready;
  assign bad_arg = 32'(cmd_arg) >= NUM_CORES;
  assign att_nx = attempts + 5'd1;
  assign give_up = !RETRY_EN || 32'(att_nx) >= RETRY_MAX;
  assign unused_rdata = ^rdata[7:1];
  always_comb begin
    state_nx = state;
    status_nx = status_r;
    case (state)
      IDLE: if (accept) begin
        status_nx = (!cmd_op[1] && bad_arg) ? 2'd2 : 2'd0;
        state_nx = (!cmd_op[1] && bad_arg) ? DONE : cmd_op == 2'd0 ? DATA :
                   cmd_op == 2'd1 ? ACK : cmd_op == 2'd2 ? LOCK_RD : UNLOCK;
      end
      DATA: if (ack && idx == 3'd7) state_nx = SEND;
      SEND, ACK, UNLOCK: if (ack) state_nx = DONE;
      LOCK_RD: if (ack) begin
        state_nx = (!rdata[0] || give_up) ? DONE : BACKOFF > 0 ? WAIT : LOCK_RD;
        status_nx = (rdata[0] && give_up) ? 2'd1 : 2'd0;
      end
      WAIT: if (32'(wait_cnt) >= BACKOFF - 1) state_nx = LOCK_RD;
      default: state_nx = IDLE;
    endcase
  end
  // Bus outputs decode straight from state so reset clears them without waiting for an edge
  assign req = state inside {DATA, SEND, ACK, LOCK_RD, UNLOCK};
  assign wen = state inside {DATA, SEND, ACK, UNLOCK};
  assign addr = state == DATA ? {9'h0A0, idx} : state == SEND ? 12'h509 : state == ACK ? 12'h50A :
                state == LOCK_RD ? {7'b0110000, arg_r, 2'b00} :
                state == UNLOCK ? {7'b0110000, arg_r, 2'b01} : 12'h000;
  assign wdata = state == DATA ? data_r[{idx, 3'b000} +: 8] :
                 (state == SEND || state == ACK) ? {5'd0, arg_r} : 8'd0;
  assign cmd_ready = state == IDLE && !rst;
  assign rsp_valid = state == DONE;
  assign rsp_status = rsp_valid ? status_r : 2'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      status_r <= 2'd0;
      data_r <= 64'd0;
      arg_r <= 3'd0;
      idx <= 3'd0;
      attempts <= 5'd0;
      wait_cnt <= 16'd0;
    end else begin
      state <= state_nx;
      status_r <= status_nx;
      if (accept) begin
        data_r <= cmd_data;
        arg_r <= cmd_arg;
        idx <= 3'd0;
        attempts <= 5'd0;
      end
      if (state == DATA && ack) idx <= idx + 3'd1;
      if (state == LOCK_RD && ack) attempts <= att_nx;
      wait_cnt <= state == WAIT ? wait_cnt + 16'd1 : 16'd0;
    end
  end
endmodule

// File: tb/tb_mp64_mbox_initiator.sv
// tb_mp64_mbox_initiator: table vectors, random commands against a transaction-list model, and reset/stall sequences.
module tb_mp64_mbox_initiator;
  localparam int NC = 4, RM = 16, BO = 4;
`ifdef MP64_MBOX_LOCK_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  localparam int MAXR = RETRY_ON ? RM : 1;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [2:0] cmd_arg = 3'd0;
  logic [63:0] cmd_data = 64'd0;
  logic cmd_ready, rsp_valid, req, wen, ack;
  logic [1:0] rsp_status;
  logic [11:0] addr;
  logic [7:0] wdata, rdata;
  mp64_mbox_initiator #(.NUM_CORES(NC), .RETRY_MAX(RM), .BACKOFF(BO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .req(req), .addr(addr), .wdata(wdata), .wen(wen), .rdata(rdata), .ack(ack)
  );
  always #5 clk = ~clk;
  logic ack_en = 1'b1;
  bit ack_rand = 1'b0;
  int busy_reads = 0, base_reads = 0, reads_done = 0;
  int n_cmp = 0, n_fail = 0, cyc = 0, rsp_cnt = 0;
  logic [20:0] log_q[$], exp_q[$];
  int log_c[$];
  logic [1:0] exp_st;
  logic pend = 1'b0;
  logic [20:0] pv = 21'd0;
  assign ack = req && ack_en;
  assign rdata = {7'h55, (reads_done - base_reads) < busy_reads};
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (ack_rand) ack_en = 1'($urandom);
  // Bus monitor: logs completed transactions and checks a stalled request holds its fields
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (req && ack) begin
      log_q.push_back({wen, addr, wdata});
      log_c.push_back(cyc);
      if (!wen) reads_done <= reads_done + 1;
    end
    if (pend && !rst) check("hold", 64'({req, wen, addr, wdata}), 64'({1'b1, pv}));
    pend <= req && !ack && !rst;
    pv <= {wen, addr, wdata};
  end
  function automatic logic [20:0] mask(input logic [20:0] t);
    return t[20] ? t : {t[20:8], 8'h00};
  endfunction
  task automatic model(input logic [1:0] op, input logic [2:0] arg, input logic [63:0] d, input int busy);
    exp_q.delete();
    exp_st = 2'd0;
    if (op < 2'd2 && int'(arg) >= NC) exp_st = 2'd2;
    else if (op == 2'd0) begin
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 12'h500 + 12'(k), d[8*k +: 8]});
      exp_q.push_back({1'b1, 12'h509, 5'd0, arg});
    end else if (op == 2'd1) exp_q.push_back({1'b1, 12'h50A, 5'd0, arg});
    else if (op == 2'd2) begin
      repeat (busy < MAXR ? busy + 1 : MAXR) exp_q.push_back({1'b0, 12'h600 + 12'(4 * arg), 8'h00});
      exp_st = busy < MAXR ? 2'd0 : 2'd1;
    end else exp_q.push_back({1'b1, 12'h601 + 12'(4 * arg), 8'h00});
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] arg, input logic [63:0] d,
                         input int busy, input int exp_lat, input string nm);
    int n, lat;
    model(op, arg, d, busy);
    busy_reads = busy;
    base_reads = reads_done;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    log_q.delete();
    log_c.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 3'($urandom); cmd_data = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
    check({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({nm, " status"}, 64'(rsp_status), 64'(exp_st));
    if (exp_lat > 0) check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " ntrans"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s trans%0d", nm, i), 64'(mask(log_q[i])), 64'(mask(exp_q[i])));
    if (exp_lat > 0 && op == 2'd2)
      for (int i = 1; i < log_c.size(); i++) check({nm, " gap"}, 64'(log_c[i] - log_c[i-1]), 64'(BO + 1));
    @(posedge clk); #1;
    check({nm, " pulse"}, 64'({rsp_valid, cmd_ready}), 64'b01);
  endtask
  typedef struct {
    logic [1:0] op; logic [2:0] arg; logic [63:0] data; int busy; int lat; string nm;
  } vec_t;
  vec_t vt[10];
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, r0;
    vt[0] = '{2'd0, 3'd2, 64'h1122334455667788, 0, 10, "send2"};
    vt[1] = '{2'd0, 3'd5, 64'hDEADBEEF00000000, 0, 1, "send_bad"};
    vt[2] = '{2'd1, 3'd4, 64'd0, 0, 1, "ack_bad"};
    vt[3] = '{2'd1, 3'd3, 64'd0, 0, 2, "ack3"};
    vt[4] = '{2'd3, 3'd7, 64'd0, 0, 2, "unlock7"};
    vt[5] = '{2'd2, 3'd3, 64'd0, 2, RETRY_ON ? 12 : 2, "lock3_110"};
    vt[6] = '{2'd2, 3'd1, 64'd0, 99, RETRY_ON ? 77 : 2, "lock1_busy"};
    vt[7] = '{2'd2, 3'd0, 64'd0, 0, 2, "lock0_free"};
    vt[8] = '{2'd0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 0, 10, "send0"};
    vt[9] = '{2'd0, 3'd7, 64'h0123456789ABCDEF, 0, 1, "send7_bad"};
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({req, wen, addr, wdata, rsp_valid, rsp_status, cmd_ready}), 64'd0);
    rst = 1'b0;
    #1;
    check("ready after reset", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    foreach (vt[i]) run_cmd(vt[i].op, vt[i].arg, vt[i].data, vt[i].busy, vt[i].lat, vt[i].nm);
    // Ack withheld for three cycles: request must sit unchanged until it completes
    log_q.delete();
    ack_en = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("stall c%0d bus", i), 64'({req, wen, addr, wdata, rsp_valid}), 64'({2'b11, 12'h50A, 8'h00, 1'b0}));
      if (i < 4) begin @(posedge clk); #1; end
    end
    ack_en = 1'b1;
    @(posedge clk); #1;
    check("stall rsp", 64'({rsp_valid, rsp_status}), 64'b100);
    check("stall ntrans", 64'(log_q.size()), 64'd1);
    @(posedge clk); #1;
    // cmd_valid held across completion is serviced again once back in IDLE
    log_q.delete();
    r0 = rsp_cnt;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 3'd1;
    repeat (4) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held valid ntrans", 64'(log_q.size()), 64'd2);
    check("held valid rsps", 64'(rsp_cnt - r0), 64'd2);
    // Reset in the middle of a SEND payload
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 3'd1; cmd_data = {$urandom, $urandom};
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (addr != 12'h504 && n < 20) begin @(posedge clk); #1; n++; end
    check("reach byte4", 64'(addr), 64'h504);
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    check("mid reset outputs", 64'({req, wen, addr, wdata, rsp_valid, rsp_status, cmd_ready}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready after mid reset", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("no rsp after reset", 64'(rsp_cnt - r0), 64'd0);
    run_cmd(2'd3, 3'd7, 64'd0, 0, 2, "unlock7_post");
    ack_rand = 1'b1;
    for (int i = 0; i < 30; i++)
      run_cmd(2'($urandom), 3'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 20)), 0,
              $sformatf("rnd%0d", i));
    ack_rand = 1'b0;
    ack_en = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
